systolic_drain: RTL
===================

Name: systolic_drain

Overview:
- Output collection stage directly downstream of systolic_top.
- Consumes per-PE accumulator results (one valid/ready pair per PE, flat index k = r*N + c) from the M x N array.
- Serialises them onto a single tagged result stream using a round-robin arbiter.
- Signals tile completion once every PE has delivered exactly one result.

Parameters:
- ACC_W, 32, accumulator/result width.
- M, 4, array rows.
- N, 4, array columns.
- IDX_W, $clog2(M*N) (localparam), width of the result index tag.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pe_out  in  M*N*ACC_W  PE k result at [k*ACC_W +: ACC_W].
- pe_out_valid  in  M*N  bit k = PE k result valid.
- pe_out_ready  out  M*N  bit k = PE k result accepted this cycle.
- res_data  out  ACC_W  serialised result.
- res_idx  out  IDX_W  source PE index k.
- res_valid  out  1  result stream valid.
- res_ready  in  1  downstream ready.
- tile_done  out  1  one-cycle pulse: all M*N results delivered.

Behaviour:
- Reset (asynchronous, any cycle):
  - res_valid=0, res_data=0, res_idx=0, tile_done=0, pe_out_ready=0.
  - seen mask=0, rr pointer=0, state=COLLECT.
  - Any partial tile is discarded.
- Handshakes:
  - Valid/ready transfer occurs on a rising edge with both high.
  - Upstream valid must not depend on pe_out_ready.
  - pe_out_ready is combinational from pe_out_valid, seen, state, ptr, res_valid and res_ready.
- Eligibility:
  - elig = pe_out_valid & ~seen.
  - Grant only when state==COLLECT and the output register is free (!res_valid || res_ready).
  - Grant = round-robin one-hot over elig, searching from ptr upward with wrap M*N-1 -> 0.
  - pe_out_ready = grant; at most one bit high per cycle.
- Capture on grant at the clock edge:
  - res_data <= pe_out slice g; res_idx <= g; res_valid <= 1.
  - seen[g] <= 1; ptr <= (g+1) mod M*N.
- Output register:
  - res_valid clears on acceptance when there is no same-cycle grant.
  - Accept and new grant in the same cycle: register reloads with no bubble. Throughput is 1 result/cycle.
  - Latency from grant to res_valid is 1 cycle.
  - While res_valid && !res_ready, res_data and res_idx are held stable.
- A PE whose seen bit is set is held off (ready=0) even if valid, until the next tile.
- FSM:
  - COLLECT: normal granting. When the grant sets the final seen bit (seen becomes all-ones) -> DRAIN.
  - DRAIN: no grants. When the output register empties (accept with res_valid) -> DONE.
  - DONE: tile_done=1 for exactly this cycle; no grants; seen<=0; ptr<=0 -> COLLECT.
- Arithmetic: pure data movement, no width change. IDX_W is computed from M*N; M*N must be >=2.

Decomposition:
- Package systolic_pkg holds:
  - ACC_W default.
  - Function clog2_safe for IDX_W.
  - State encoding localparams COLLECT=2'd0, DRAIN=2'd1, DONE=2'd2.
- Sub-module rr_arbiter (parameter REQ=M*N):
  - Inputs: req, ptr, en.
  - Outputs: one-hot gnt, encoded gnt_idx, any.
  - Purely combinational; the pointer register stays in systolic_drain.

Test Plan:
- Full tile:
  - Stimulus: all 16 PEs valid, pe_out[k]=10*k, res_ready=1.
  - Required: idx 0..15 on 16 consecutive cycles starting 1 cycle after the first grant, data 0,10,...,150.
  - Required: tile_done high exactly one cycle, in the cycle after idx 15 is accepted.
- Backpressure:
  - Stimulus: PE 2 valid with 77; res_ready=0 for 5 cycles, then 1.
  - Required: res_valid=1, res_data=77, res_idx=2 held stable for all 5 cycles.
  - Required: only one pe_out_ready[2] pulse; no other grant until acceptance.
- Round-robin:
  - Stimulus: PEs 3 and 12 valid, then PE 1 raised after PE 3 is granted.
  - Required order 3, 12, 1: pointer wraps past 15 to 0 before PE 1 is served.
- Duplicate hold-off:
  - Stimulus: PE 5 delivers 9, then re-asserts valid with 11 mid-tile.
  - Required: pe_out_ready[5]=0 until tile_done.
  - Required: 11 appears with idx 5 as the first result of the next tile (ptr=0, only PE 5 pending).
- Reset mid-tile:
  - Stimulus: assert rst asynchronously after 7 results accepted.
  - Required: res_valid, pe_out_ready and tile_done go 0 immediately, without a clock edge.
  - Required after release: a fresh 16-result tile yields tile_done only after all 16.
- Zero-bubble:
  - Stimulus: res_ready=1 with continuous requests.
  - Required: res_valid never drops between consecutive results within a tile.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared constants, FSM encoding and sizing helper for the systolic result drain.
package systolic_pkg;

    localparam int ACC_W_DEF = 32;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Index width for n sources; never below 1 so a tag port always exists.
    function automatic int clog2_safe(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping to 0.
module rr_arbiter
    import systolic_pkg::*;
#(
    parameter  int REQ = 16,
    localparam int IW  = clog2_safe(REQ)
) (
    input  logic [REQ-1:0] req,
    input  logic [IW-1:0]  ptr,
    input  logic           en,
    output logic [REQ-1:0] gnt,
    output logic [IW-1:0]  gnt_idx,
    output logic           any
);

    logic [REQ-1:0] req_m_s;
    logic [IW-1:0]  pos_s;
    logic           hit_s;

    assign req_m_s = req & {REQ{en}};

    // Circular scan from ptr; only the first hit survives because any blocks later ones.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        pos_s   = '0;
        hit_s   = 1'b0;
        for (int i = 0; i < REQ; i++) begin
            pos_s        = IW'((int'(ptr) + i) % REQ);
            hit_s        = req_m_s[pos_s] && !any;
            gnt[pos_s]   = hit_s;
            gnt_idx      = hit_s ? pos_s : gnt_idx;
            any          = any | hit_s;
        end
    end

endmodule

// File: rtl/systolic_drain.sv
// Serialises one result per PE onto a tagged stream and pulses tile_done per full tile.
module systolic_drain
    import systolic_pkg::*;
#(
    parameter  int ACC_W = ACC_W_DEF,
    parameter  int M     = 4,
    parameter  int N     = 4,
    localparam int IDX_W = clog2_safe(M * N)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [M*N*ACC_W-1:0]   pe_out,
    input  logic [M*N-1:0]         pe_out_valid,
    output logic [M*N-1:0]         pe_out_ready,
    output logic [ACC_W-1:0]       res_data,
    output logic [IDX_W-1:0]       res_idx,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   tile_done
);

    localparam int PES = M * N;

    state_t           state_r;
    state_t           next_state_s;
    logic [PES-1:0]   seen_r;
    logic [PES-1:0]   seen_next_s;
    logic [PES-1:0]   elig_s;
    logic [PES-1:0]   gnt_s;
    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W-1:0] ptr_next_s;
    logic [IDX_W-1:0] gnt_idx_s;
    logic             any_s;
    logic             free_s;
    logic             arb_en_s;
    logic             accept_s;
    logic             all_seen_s;
    logic [ACC_W-1:0] cap_data_s;

    assign elig_s      = pe_out_valid & ~seen_r;
    assign free_s      = !res_valid || res_ready;
    // Held in reset the FSM reads COLLECT, so grants are suppressed explicitly.
    assign arb_en_s    = !rst && (state_r == COLLECT) && free_s;
    assign accept_s    = res_valid && res_ready;
    assign seen_next_s = seen_r | gnt_s;
    assign all_seen_s  = &seen_next_s;
    assign ptr_next_s  = (gnt_idx_s == IDX_W'(PES - 1)) ? '0 : gnt_idx_s + IDX_W'(1);
    assign pe_out_ready = gnt_s;

    rr_arbiter #(
        .REQ (PES)
    ) u_arb (
        .req     (elig_s),
        .ptr     (ptr_r),
        .en      (arb_en_s),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .any     (any_s)
    );

    // One-hot AND-OR select of the granted PE's result.
    always_comb begin
        cap_data_s = '0;
        for (int k = 0; k < PES; k++) begin
            cap_data_s = cap_data_s | (pe_out[k*ACC_W +: ACC_W] & {ACC_W{gnt_s[k]}});
        end
    end

    // Tile FSM next-state: collect until every PE has been granted, drain the last result, pulse done.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            COLLECT: begin
                if (any_s && all_seen_s) next_state_s = DRAIN;
                else                     next_state_s = COLLECT;
            end
            DRAIN: begin
                if (accept_s) next_state_s = DONE;
                else          next_state_s = DRAIN;
            end
            DONE:    next_state_s = COLLECT;
            default: next_state_s = COLLECT;
        endcase
    end

    // FSM state and registered done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= COLLECT;
            tile_done <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            tile_done <= (next_state_s == DONE);
        end
    end

    // Output register: a grant reloads it even while the current word is being accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_idx   <= '0;
        end else if (any_s) begin
            res_valid <= 1'b1;
            res_data  <= cap_data_s;
            res_idx   <= gnt_idx_s;
        end else if (accept_s) begin
            res_valid <= 1'b0;
        end else begin
            res_valid <= res_valid;
        end
    end

    // Per-tile delivery mask and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_r <= '0;
            ptr_r  <= '0;
        end else if (state_r == DONE) begin
            seen_r <= '0;
            ptr_r  <= '0;
        end else if (any_s) begin
            seen_r <= seen_next_s;
            ptr_r  <= ptr_next_s;
        end else begin
            seen_r <= seen_r;
            ptr_r  <= ptr_r;
        end
    end

endmodule
